// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit with valid/ready handshakes, tag passthrough and flush.
// Optional macro MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are all zero.
module ex_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W    = $clog2(XLEN + 1);
  localparam int MUL_ITER = XLEN / MUL_BPC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic                mul_corr_q, mul_corr_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_result_q, out_result_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;

  logic                accept;
  logic                is_div;
  logic                signed_div;
  logic                signed_mul_a;
  logic                a_neg;
  logic                b_neg;
  logic                div_zero;
  logic                div_ovf;
  logic                mul_skip;
  logic [2*XLEN-1:0]   mul_sum;
  logic [2*XLEN-1:0]   mul_fixed;
  logic [XLEN:0]       div_diff;
  logic [XLEN-1:0]     quot;
  logic [XLEN-1:0]     rem;

  assign in_ready   = (state_q == S_IDLE) && !flush;
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

  assign accept       = in_valid && in_ready;
  assign is_div       = in_funct3[2];
  assign signed_div   = in_funct3[2] && !in_funct3[0];
  assign signed_mul_a = !in_funct3[2] && (in_funct3[1] ^ in_funct3[0]);
  assign a_neg        = in_opa[XLEN-1];
  assign b_neg        = in_opb[XLEN-1];
  assign div_zero     = (in_opb == '0);
  assign div_ovf      = signed_div && (in_opa == {1'b1, {(XLEN-1){1'b0}}}) && (&in_opb);

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_skip = (b_q == '0);
`else
  assign mul_skip = 1'b0;
`endif

  // Multiplicand shifted into place for each set bit of the current multiplier digit.
  always_comb begin
    mul_sum = acc_q;
    for (int i = 0; i < MUL_BPC; i++) begin
      if (b_q[i]) begin
        mul_sum = mul_sum + (mcand_q << i);
      end
    end
  end

  // Only XLEN multiplier bits are iterated; a negative signed rs2 is fixed up by subtracting opa<<XLEN.
  assign mul_fixed = acc_q - (mul_corr_q ? {a_q, {XLEN{1'b0}}} : {(2*XLEN){1'b0}});
  assign div_diff  = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
  assign quot      = q_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem       = r_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    tag_d        = tag_q;
    a_d          = a_q;
    b_d          = b_q;
    mcand_d      = mcand_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    mul_corr_d   = mul_corr_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d = in_funct3;
          tag_d    = in_tag;
          a_d      = in_opa;
          if (is_div && (div_zero || div_ovf)) begin
            if (div_zero) begin
              out_result_d = in_funct3[1] ? in_opa : {XLEN{1'b1}};
            end else begin
              out_result_d = in_funct3[1] ? {XLEN{1'b0}} : in_opa;
            end
            out_tag_d   = in_tag;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (is_div) begin
            b_d     = (signed_div && b_neg) ? -in_opb : in_opb;
            acc_d   = {{XLEN{1'b0}}, ((signed_div && a_neg) ? -in_opa : in_opa)};
            cnt_d   = CNT_W'(XLEN - 1);
            q_neg_d = signed_div && (a_neg ^ b_neg);
            r_neg_d = signed_div && a_neg;
            state_d = S_DIV;
          end else begin
            mcand_d    = {{XLEN{signed_mul_a && a_neg}}, in_opa};
            b_d        = in_opb;
            acc_d      = '0;
            cnt_d      = CNT_W'(MUL_ITER - 1);
            mul_corr_d = (in_funct3 == 3'b001) && b_neg;
            state_d    = S_MUL;
          end
        end
      end

      S_MUL: begin
        if (mul_skip) begin
          state_d = S_FIX;
        end else begin
          acc_d   = mul_sum;
          mcand_d = mcand_q << MUL_BPC;
          b_d     = b_q >> MUL_BPC;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
      end

      // Restoring step: trial-subtract the divisor from the shifted partial remainder.
      S_DIV: begin
        if (!div_diff[XLEN]) begin
          acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        case (funct3_q)
          3'b000:                 out_result_d = mul_fixed[XLEN-1:0];
          3'b001, 3'b010, 3'b011: out_result_d = mul_fixed[2*XLEN-1:XLEN];
          3'b100, 3'b101:         out_result_d = quot;
          default:                out_result_d = rem;
        endcase
        out_tag_d   = tag_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      funct3_q     <= '0;
      tag_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mcand_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      mul_corr_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      tag_q        <= tag_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mcand_q      <= mcand_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      mul_corr_q   <= mul_corr_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed scoreboard bench for ex_muldiv_unit: results, tags, latencies, backpressure and flush.
// Multiply latency expectations follow MULDIV_EARLY_OUT_EN when the bench is built with it.
module tb_ex_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int BPC   = 2;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic [7:0]       lat;
  } sb_entry_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_opa;
  logic [XLEN-1:0]  in_opb;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int        test_count = 0;
  int        fail_count = 0;
  sb_entry_t sb_q[$];
  sb_entry_t held;
  int        stray_valid;

  ex_muldiv_unit #(.XLEN(XLEN), .MUL_BPC(BPC), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_opa     (in_opa),
    .in_opb     (in_opb),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] mulLat(input logic [XLEN-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    int k;
    int cyc;
    k = 0;
    for (int i = 0; i < XLEN; i++) begin
      if (b[i]) k = i / BPC + 1;
    end
    cyc = (k + 1 > XLEN / BPC) ? XLEN / BPC : k + 1;
    return 8'(cyc + 2);
`else
    return 8'(XLEN / BPC + 2);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                               input logic [XLEN-1:0] exp_res, input logic [7:0] exp_lat);
    sb_entry_t e;
    e.result = exp_res;
    e.tag    = tag;
    e.lat    = exp_lat;
    sb_q.push_back(e);
    @(negedge clk);
    in_funct3 = f3;
    in_opa    = a;
    in_opb    = b;
    in_tag    = tag;
    in_valid  = 1'b1;
    #1;
    checkOutput("in_ready_at_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_opa    = $urandom;
    in_opb    = $urandom;
    in_tag    = TAG_W'($urandom);
    in_funct3 = 3'($urandom);
  endtask

  // Waits for out_valid, compares against the scoreboard head; optionally completes the handshake.
  task automatic waitResult(input string name, input bit handshake, output sb_entry_t e);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    e = sb_q.pop_front();
    checkOutput({name, "_latency"}, 64'(lat), 64'(e.lat));
    checkOutput({name, "_result"}, 64'(out_result), 64'(e.result));
    checkOutput({name, "_tag"}, 64'(out_tag), 64'(e.tag));
    if (handshake) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, "_valid_drop"}, 64'(out_valid), 64'd0);
      checkOutput({name, "_ready_after"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    sb_entry_t e;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_funct3 = 3'd0;
    in_opa    = '0;
    in_opb    = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_result", 64'(out_result), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, mulLat(32'hFFFF_FFFD));
    waitResult("mul_7_neg3", 1'b1, e);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, mulLat(32'hFFFF_FFFF));
    waitResult("mulhu_max", 1'b1, e);
    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, mulLat(32'hFFFF_FFFF));
    waitResult("mulh_m1_m1", 1'b1, e);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF, mulLat(32'd2));
    waitResult("mulhsu_m1_2", 1'b1, e);
    applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd13, 32'h4000_0000, mulLat(32'h8000_0000));
    waitResult("mulh_min_min", 1'b1, e);
    applyStimulus(3'b000, 32'd6, 32'd0, 5'd7, 32'd0, mulLat(32'd0));
    waitResult("mul_by_zero", 1'b1, e);

    applyStimulus(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd8, 32'hFFFF_FFFA, 8'd34);
    waitResult("div_m20_3", 1'b1, e);
    applyStimulus(3'b110, 32'hFFFF_FFEC, 32'd3, 5'd9, 32'hFFFF_FFFE, 8'd34);
    waitResult("rem_m20_3", 1'b1, e);
    applyStimulus(3'b101, 32'd100, 32'd7, 5'd10, 32'd14, 8'd34);
    waitResult("divu_100_7", 1'b1, e);
    applyStimulus(3'b111, 32'd100, 32'd7, 5'd11, 32'd2, 8'd34);
    waitResult("remu_100_7", 1'b1, e);
    applyStimulus(3'b100, 32'd20, 32'hFFFF_FFFD, 5'd14, 32'hFFFF_FFFA, 8'd34);
    waitResult("div_20_m3", 1'b1, e);
    applyStimulus(3'b110, 32'd20, 32'hFFFF_FFFD, 5'd15, 32'd2, 8'd34);
    waitResult("rem_20_m3", 1'b1, e);

    applyStimulus(3'b101, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 8'd1);
    waitResult("divu_by_zero", 1'b1, e);
    applyStimulus(3'b110, 32'd5, 32'd0, 5'd17, 32'd5, 8'd1);
    waitResult("rem_by_zero", 1'b1, e);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 8'd1);
    waitResult("div_overflow", 1'b1, e);
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0, 8'd1);
    waitResult("rem_overflow", 1'b1, e);

    // Backpressure: hold the result for 10 cycles while a competing request is offered.
    out_ready = 1'b0;
    applyStimulus(3'b111, 32'd9, 32'd0, 5'd12, 32'd9, 8'd1);
    waitResult("bp_remu_zero", 1'b0, held);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_funct3 = 3'b000;
      in_opa    = 32'd1;
      in_opb    = 32'd1;
      in_tag    = 5'd31;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_valid_hold", 64'(out_valid), 64'd1);
      checkOutput("bp_result_hold", 64'(out_result), 64'(held.result));
      checkOutput("bp_tag_hold", 64'(out_tag), 64'(held.tag));
      checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_valid_drop", 64'(out_valid), 64'd0);
    checkOutput("bp_in_ready_after", 64'(in_ready), 64'd1);
    stray_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid || busy) stray_valid++;
    end
    checkOutput("bp_no_queued_op", 64'(stray_valid), 64'd0);

    // Flush a divide mid-flight; its result must never appear.
    @(negedge clk);
    in_funct3 = 3'b101;
    in_opa    = 32'd1000;
    in_opb    = 32'd3;
    in_tag    = 5'd20;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready_low", 64'(in_ready), 64'd0);
    checkOutput("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy_after", 64'(busy), 64'd0);
    checkOutput("flush_in_ready_after", 64'(in_ready), 64'd1);
    stray_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stray_valid++;
    end
    checkOutput("flush_no_result", 64'(stray_valid), 64'd0);

    applyStimulus(3'b000, 32'd6, 32'd7, 5'd9, 32'd42, mulLat(32'd7));
    waitResult("mul_after_flush", 1'b1, e);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multi-cycle execute unit for the RV32M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits in the EX stage beside the single-cycle ALU. The decoder steers M-extension instructions here by funct3.
- Generalises the single-cycle ALU multiply: parametrised operand width and multiplier radix, full high-word and divide/remainder support, a valid/ready handshake in both directions, tag passthrough and pipeline flush.

Parameters:
- XLEN, 32, operand/result width (even, >=8).
- MUL_BPC, 2, multiplier bits retired per cycle (1, 2 or 4; must divide XLEN).
- TAG_W, 5, width of the opaque tag (destination register) carried with the op.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the in-flight op and any pending result
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_opa  in  XLEN  rs1 value
- in_opb  in  XLEN  rs2 value
- in_tag  in  TAG_W  tag, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of the result
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE, out_valid=0, out_result=0, out_tag=0, busy=0. in_ready=1 from the first cycle after reset.
- in_ready = (state==IDLE) & ~flush. Accept occurs when in_valid & in_ready at a clk edge. Operands, funct3 and tag are latched at that edge; inputs are don't-care afterwards.
- States: IDLE -> MUL | DIV | DONE(special) ; MUL -> FIX ; DIV -> FIX ; FIX -> DONE ; DONE -> IDLE on out_valid & out_ready.
- MUL:
  - Operands are sign- or zero-extended to 2*XLEN per op: MULH signed x signed, MULHSU signed x unsigned, MUL/MULHU unsigned.
  - Shift-add retires MUL_BPC bits per cycle for XLEN/MUL_BPC cycles into a 2*XLEN accumulator, computed modulo 2^(2*XLEN).
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- DIV: restoring radix-2 divide on operand magnitudes, XLEN cycles.
- FIX: one cycle. Applies sign correction: quotient is negated if the operand signs differ; remainder takes the sign of the dividend. Then selects the result.
- Latency, accept edge to first cycle out_valid=1:
  - multiply ops: XLEN/MUL_BPC+2 cycles.
  - divide ops: XLEN+2 cycles.
  - special cases: 1 cycle.
- Special cases are detected at accept and go directly to DONE:
  - divisor 0: DIV/DIVU -> all ones; REM/REMU -> opa.
  - signed overflow, DIV with opa=100..0 and opb=all ones: DIV -> opa; REM -> 0.
- DONE: out_valid=1. out_result and out_tag hold stable until out_ready. The accept of a new request occurs earliest in the cycle after the handshake (no back-to-back overlap).
- flush: takes priority over every transition. At the next edge: state=IDLE, out_valid=0, any result is discarded. in_ready=0 during the flush cycle. If flush and out_ready are both high in DONE, the result counts as dropped, not delivered.
- rst mid-operation behaves as flush and also clears out_result and out_tag.
- in_valid while busy is ignored and not queued.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - MUL state ends early once the remaining unprocessed multiplier bits are all zero; proceeds to FIX the following cycle.
  - Latency then ranges from 3 cycles (opb=0) to XLEN/MUL_BPC+2.
  - Results are bit-identical to the undefined build.
- Undefined: multiply latency is fixed at XLEN/MUL_BPC+2 regardless of operands.
- Division latency is unaffected in both builds.

Test Plan:
- MUL opa=7, opb=0xFFFFFFFD, tag=3, out_ready=1 -> result 0xFFFFFFEB, out_tag=3, out_valid rises 18 cycles after accept (MUL_BPC=2, early-out off).
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU opa=0xFFFFFFFF, opb=2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFEC / 3 -> 0xFFFFFFFA; REM same -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU 100/7 -> 2; each in 34 cycles.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; all 1 cycle.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, result and tag stable, in_ready=0, new in_valid ignored. After the handshake, in_ready=1 the next cycle.
- Flush at cycle 5 of a DIV -> busy=0 and in_ready=1 the cycle after; out_valid never asserts for it. A following MUL 6x7 -> 42 with the correct tag.
